// File: rtl/hack_pkg.sv
// rtl/hack_pkg.sv - shared Hack encodings, state enum and default width
package hack_pkg;

    localparam int HACK_WIDTH = 16;

    typedef enum logic [2:0] {
        JNULL = 3'b000,
        JGT   = 3'b001,
        JEQ   = 3'b010,
        JGE   = 3'b011,
        JLT   = 3'b100,
        JNE   = 3'b101,
        JLE   = 3'b110,
        JMP   = 3'b111
    } jump_e;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } pc_state_e;

endpackage

// File: rtl/and_gate.sv
// rtl/and_gate.sv - two-input And primitive
module and_gate (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = a & b;
endmodule

// File: rtl/jump_cond.sv
// rtl/jump_cond.sv - combinational Hack jump-condition decode from gate primitives
module jump_cond (
    input  logic       is_c,
    input  logic [2:0] jmp,
    input  logic       zr,
    input  logic       ng,
    output logic       jump
);
    logic not_ng;
    logic not_zr;
    logic term_lt;
    logic term_eq;
    logic term_gt_pos;
    logic term_gt;
    logic lt_or_eq;
    logic any_term;

    not_gate u_not_ng (.a(ng), .y(not_ng));
    not_gate u_not_zr (.a(zr), .y(not_zr));

    and_gate u_and_lt  (.a(jmp[2]),      .b(ng),     .y(term_lt));
    and_gate u_and_eq  (.a(jmp[1]),      .b(zr),     .y(term_eq));
    and_gate u_and_gt0 (.a(jmp[0]),      .b(not_ng), .y(term_gt_pos));
    and_gate u_and_gt1 (.a(term_gt_pos), .b(not_zr), .y(term_gt));

    or_gate  u_or_le   (.a(term_lt),  .b(term_eq), .y(lt_or_eq));
    or_gate  u_or_all  (.a(lt_or_eq), .b(term_gt), .y(any_term));

    // A-instructions never jump, whatever bits happen to sit in the jump field.
    and_gate u_and_c   (.a(is_c), .b(any_term), .y(jump));
endmodule

// File: rtl/not_gate.sv
// rtl/not_gate.sv - inverter primitive
module not_gate (
    input  logic a,
    output logic y
);
    assign y = ~a;
endmodule

// File: rtl/or_gate.sv
// rtl/or_gate.sv - two-input Or primitive
module or_gate (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = a | b;
endmodule

// File: rtl/program_counter.sv
// rtl/program_counter.sv - Hack PC with jump evaluation and self-jump halt detection
module program_counter
    import hack_pkg::*;
#(
    parameter int WIDTH = HACK_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             is_c,
    input  logic [2:0]       jmp,
    input  logic             zr,
    input  logic             ng,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    output logic             jump_taken,
    output logic             halted
);
    pc_state_e        state;
    logic             jump;
    logic             self_jump;
    logic [WIDTH-1:0] out_inc;

    jump_cond u_jump_cond (
        .is_c (is_c),
        .jmp  (jmp),
        .zr   (zr),
        .ng   (ng),
        .jump (jump)
    );

    assign out_inc = out + WIDTH'(1);

    // Only the unconditional form counts as end-of-program; conditional self-jumps are ordinary.
    assign self_jump = (jmp == JMP) && (in == out);

    always_ff @(posedge clk) begin
        if (reset) begin
            out        <= '0;
            jump_taken <= 1'b0;
            state      <= RUN;
        end else begin
            case (state)
                RUN: begin
                    if (!en) begin
                        jump_taken <= 1'b0;
                    end else if (jump) begin
                        out        <= in;
                        jump_taken <= 1'b1;
                        if (self_jump) begin
                            state <= HALT;
                        end
                    end else begin
                        out        <= out_inc;
                        jump_taken <= 1'b0;
                    end
                end
                HALT: begin
                    jump_taken <= 1'b0;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

    assign halted = (state == HALT);
endmodule

// File: tb/tb_program_counter.sv
// tb/tb_program_counter.sv - scoreboard bench for program_counter
module tb_program_counter;
    import hack_pkg::*;

    localparam int W = 16;

    logic         clk;
    logic         reset;
    logic         en;
    logic         is_c;
    logic [2:0]   jmp;
    logic         zr;
    logic         ng;
    logic [W-1:0] in;
    logic [W-1:0] out;
    logic         jump_taken;
    logic         halted;

    program_counter #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .is_c       (is_c),
        .jmp        (jmp),
        .zr         (zr),
        .ng         (ng),
        .in         (in),
        .out        (out),
        .jump_taken (jump_taken),
        .halted     (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] out;
        logic         jt;
        logic         halt;
        int           id;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   checks = 0;
    int   errors = 0;
    int   step_id = 0;

    logic [W-1:0] m_out  = '0;
    logic         m_jt   = 1'b0;
    logic         m_halt = 1'b0;

    // Reference model: a program counter with a sign-class jump test.
    task automatic step(input bit r, input bit e, input bit c, input logic [2:0] j,
                        input bit z, input bit n, input logic [W-1:0] a);
        bit take;
        exp_t x;
        @(negedge clk);
        reset = r; en = e; is_c = c; jmp = j; zr = z; ng = n; in = a;
        take = c && ((j[2] && n) || (j[1] && z) || (j[0] && !n && !z));
        if (r) begin
            m_out = '0; m_jt = 1'b0; m_halt = 1'b0;
        end else if (m_halt || !e) begin
            m_jt = 1'b0;
        end else if (take) begin
            if (j == 3'b111 && a == m_out) m_halt = 1'b1;
            m_out = a;
            m_jt  = 1'b1;
        end else begin
            m_out = (m_out == {W{1'b1}}) ? '0 : m_out + 1;
            m_jt  = 1'b0;
        end
        x.out = m_out; x.jt = m_jt; x.halt = m_halt; x.id = step_id;
        exp_q.push_back(x);
        step_id++;
    endtask

    task automatic preload(input logic [W-1:0] a);
        if (m_out == a) step(0, 1, 0, 3'b000, 0, 0, '0);
        step(0, 1, 1, 3'b111, 0, 0, a);
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            checks++;
            if (out !== cur.out) begin
                errors++;
                $display("FAIL out step=%0d got=%h expected=%h", cur.id, out, cur.out);
            end
            checks++;
            if (jump_taken !== cur.jt) begin
                errors++;
                $display("FAIL jump_taken step=%0d got=%b expected=%b", cur.id, jump_taken, cur.jt);
            end
            checks++;
            if (halted !== cur.halt) begin
                errors++;
                $display("FAIL halted step=%0d got=%b expected=%b", cur.id, halted, cur.halt);
            end
        end
    end

    initial begin
        reset = 1'b1; en = 1'b0; is_c = 1'b0; jmp = 3'b000; zr = 1'b0; ng = 1'b0; in = '0;

        step(1, 0, 0, 3'b000, 0, 0, 16'h1234);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 3'b111, 1, 1, 16'h0000);

        preload(16'h0010);
        step(0, 1, 1, JLT, 0, 1, 16'h0100);
        preload(16'h0010);
        step(0, 1, 1, JLT, 0, 0, 16'h0100);

        for (int j = 0; j < 8; j++) begin
            for (int f = 0; f < 3; f++) begin
                step(0, 1, 1, 3'(j), f == 0, f == 1, 16'(16'h1000 + 16 * (j * 3 + f)));
            end
        end
        step(0, 1, 1, JEQ, 1, 1, 16'h0777);
        step(0, 1, 1, JGT, 1, 1, 16'h0778);

        preload(16'hFFFF);
        step(0, 1, 0, JNULL, 0, 0, 16'hFFFF);
        step(0, 1, 0, JNULL, 0, 0, 16'hFFFF);

        preload(16'h002A);
        step(0, 1, 1, JMP, 0, 0, 16'h002A);
        for (int i = 0; i < 10; i++)
            step(0, 1'($urandom), 1'($urandom), 3'($urandom), 1'($urandom), 1'($urandom), 16'($urandom));
        step(1, 1, 1, JMP, 0, 0, 16'h0055);
        step(0, 1, 0, JNULL, 0, 0, 16'h0000);

        preload(16'h002A);
        step(0, 1, 1, JEQ, 1, 0, 16'h002A);
        step(0, 0, 1, JMP, 0, 0, 16'h0050);
        step(0, 0, 1, JMP, 0, 0, 16'h0050);

        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 40) == 0, $urandom_range(0, 3) != 0, 1'($urandom),
                 3'($urandom), 1'($urandom), 1'($urandom),
                 ($urandom_range(0, 15) == 0) ? m_out : 16'($urandom));
        end

        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d expected=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/program_counter.md
# program_counter

Hack program counter with integrated jump-condition evaluation. The block decodes the C-instruction jump field against the ALU status flags and selects the next instruction address: reset, jump target, increment, or hold. Its OR-reduction of the three jump terms is built from the team's Or/And/Not gate primitives. It sits between the ALU/A-register and the instruction ROM address port, and detects the Hack end-of-program idiom (unconditional jump to self) as a halt.

## Interface
- WIDTH, 16, address width of the counter and of the jump target
- clk  input  1  rising-edge clock; the block uses only this clock
- reset  input  1  synchronous, active-high; sampled on rising clk
- en  input  1  step strobe from CPU control; the PC advances only when en=1
- is_c  input  1  current instruction is C-type; gates all jump evaluation
- jmp  input  3  jump bits {j1,j2,j3}: j1 = less than zero, j2 = equal to zero, j3 = greater than zero
- zr  input  1  ALU output == 0
- ng  input  1  ALU output < 0
- in  input  WIDTH  jump target (A register)
- out  output  WIDTH  current instruction address (registered)
- jump_taken  output  1  registered; 1 for exactly one cycle after a taken jump
- halted  output  1  registered; 1 while the block is in HALT

## Operation
- jump term: is_c & ((j1 & ng) | (j2 & zr) | (j3 & ~ng & ~zr)).
- jmp=000 never jumps. jmp=111 always jumps when is_c=1.
- States: RUN and HALT. Reset value: RUN.
- RUN, en=0: hold out; jump_taken←0.
- RUN, en=1, jump=1: out←in; jump_taken←1.
- RUN, en=1, jump=1, jmp=111, in==out: additionally state←HALT.
- RUN, en=1, jump=0: out←out+1, modulo 2^WIDTH (all-ones wraps to 0); jump_taken←0.
- HALT: out holds; jump_taken←0; en, jmp and flags are ignored. Only reset exits HALT.
- halted = (state==HALT).
- A conditional jump to self (jmp≠111) that is taken with in==out is an ordinary jump and does not halt.
- Priority: reset > HALT hold > en=0 hold > jump > increment.
- Reset values: out=0, jump_taken=0, halted=0, state=RUN. Reset asserted mid-operation or in HALT returns to these values on the next edge, regardless of all other inputs.
- Contradictory flags (zr=1 and ng=1) are evaluated literally by the jump term; no error is raised.

## Timing
- All outputs are registered. A decision made at edge N is visible on out, jump_taken and halted after edge N.
- Latency from en/jump inputs to out: 1 cycle. No combinational path from any input to any output.
- halted rises in the same cycle that out holds the self-jump target. jump_taken is also 1 in that cycle.
- Back-to-back en=1 cycles advance out once per clock, with no bubbles.

## Structure
- Shared package (hack_pkg): jump-field encodings NULL=000, JGT=001, JEQ=010, JGE=011, JLT=100, JNE=101, JLE=110, JMP=111; state enum {RUN, HALT}; default WIDTH constant.
- Sub-module jump_cond: purely combinational; inputs is_c, jmp, zr, ng; output jump. It is composed of existing And/Or/Not instances and is reusable by the CPU control block.
- Top level holds the out register, the state register, the incrementer, the next-address mux and the halt comparator.

## Test plan
- Reset, then en=1 for 5 cycles with is_c=0 → out = 0,1,2,3,4,5; jump_taken=0 throughout.
- out=0x0010, is_c=1, jmp=JLT, ng=1, in=0x0100, en=1 → out=0x0100 next cycle with jump_taken=1; same stimulus with ng=0 → out=0x0011.
- Sweep all 8 jmp codes × flag sets {zr=1,ng=0}, {zr=0,ng=1}, {zr=0,ng=0} → jump_taken matches the truth table, e.g. JNE with zr=1 → no jump, JGE with zr=1 → jump.
- Preload out=0xFFFF, en=1, no jump → out=0x0000, no halt, no X.
- out=0x002A, is_c=1, jmp=JMP, in=0x002A, en=1 → out=0x002A, halted=1; then 10 cycles of random en/jmp/in → out stays 0x002A; reset → out=0, halted=0.
- Same self-target but jmp=JEQ with zr=1 → out=0x002A, halted=0. en=0 with a valid jump presented → out unchanged.
